// File: rtl/mult_accumulator.sv
// Run-length product accumulator with a one-deep staging register ahead of the adder.
// Optional build macro MULT_ACC_SAT_EN selects saturating instead of wrapping accumulation.
module mult_accumulator #(
    parameter int unsigned SIZE  = 16,
    parameter int unsigned GUARD = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic                        Clock,
    input  logic                        Reset,
    input  logic                        iStart,
    input  logic [CNT_W-1:0]            iLength,
    input  logic                        iValid,
    input  logic [2*SIZE-1:0]           iProduct,
    output logic                        oReady,
    output logic [2*SIZE+GUARD-1:0]     oAcc,
    output logic                        oDone,
    output logic                        oBusy,
    output logic                        oOverflow
);

    localparam int unsigned PROD_W = 2 * SIZE;
    localparam int unsigned ACC_W  = 2 * SIZE + GUARD;
    localparam int unsigned SUM_W  = ACC_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    count;
    logic                stage_vld;
    logic [PROD_W-1:0]   stage;
    logic                beat;
    logic [SUM_W-1:0]    sum;
    logic [ACC_W-1:0]    add_res;

    // Ready depends only on state and iStart, never on iValid.
    assign oReady = (state == ACC) && (count != '0) && !iStart;
    assign beat   = iValid && oReady;
    assign sum    = {1'b0, oAcc} + SUM_W'(stage);

`ifdef MULT_ACC_SAT_EN
    assign add_res = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
`else
    assign add_res = sum[ACC_W-1:0];
`endif

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state     <= IDLE;
            count     <= '0;
            stage_vld <= 1'b0;
            stage     <= '0;
            oAcc      <= '0;
            oDone     <= 1'b0;
            oBusy     <= 1'b0;
            oOverflow <= 1'b0;
        end else if (iStart) begin
            // A new run pre-empts anything in flight, including a staged product.
            oAcc      <= '0;
            oOverflow <= 1'b0;
            count     <= iLength;
            stage_vld <= 1'b0;
            oDone     <= (iLength == '0);
            oBusy     <= (iLength != '0);
            state     <= (iLength == '0) ? DONE : ACC;
        end else begin
            oDone     <= 1'b0;
            stage_vld <= beat;
            if (beat) begin
                stage <= iProduct;
            end
            if (stage_vld) begin
                oAcc <= add_res;
                if (sum[ACC_W]) begin
                    oOverflow <= 1'b1;
                end
            end
            case (state)
                IDLE: begin
                end
                ACC: begin
                    if (beat) begin
                        count <= count - CNT_W'(1);
                        if (count == CNT_W'(1)) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    state <= DONE;
                    oDone <= 1'b1;
                    oBusy <= 1'b0;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
